// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage with the IF/ID pipeline register.
//
// Keeps the PC and issues one word fetch at a time over a valid/ready
// request channel. The response channel carries only a valid. Fetched
// instructions go into the decode slot {if_id_valid, if_id_pc, if_id_instr}.
// A one-entry hold buffer catches a response that arrives while decode is
// stalled. A redirect from EX flushes the slot and the hold buffer, and it
// discards the response of any request still in flight.
//
// Ports:
//   clk, rst_n                  clock (rising edge), async active-low reset
//   imem_req_valid/ready        fetch request handshake
//   imem_addr                   word-aligned fetch byte address
//   imem_rsp_valid/data         fetch response (one per accepted request)
//   redirect_valid/pc           EX redirect (flush) and its target
//   if_id_valid/pc/instr        decode slot (instr is NOP_INSTR when invalid)
//   id_ready                    decode consumes the slot; low = stall
//   perf_fetched/discarded      event counters (FETCH_PERF_CNT_EN only)
//
// Optional build macro: FETCH_PERF_CNT_EN adds the two performance counters.
module fetch_stage #(
  parameter int              XLEN      = 64,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h00000013
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_pc,
  output logic [31:0]     if_id_instr,
`ifdef FETCH_PERF_CNT_EN
  output logic [63:0]     perf_fetched,
  output logic [63:0]     perf_discarded,
`endif
  input  logic            id_ready
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  state_t          state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_inflight;
  logic            hold_valid;
  logic [XLEN-1:0] hold_pc;
  logic [31:0]     hold_instr;

  logic req_fire;
  logic rsp_take;
  logic slot_free;

  // The request is gated with rst_n so that it is low during reset, when
  // the FSM otherwise sits in S_REQ.
  assign imem_req_valid = rst_n && (state == S_REQ) && !redirect_valid && !hold_valid;
  assign imem_addr      = pc & ALIGN_MASK;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_take       = (state == S_WAIT) && imem_rsp_valid && !redirect_valid;
  // The slot can take a new entry when it is empty or is consumed this cycle.
  assign slot_free      = !if_id_valid || id_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_REQ;
      pc          <= RESET_PC;
      pc_inflight <= '0;
      if_id_valid <= 1'b0;
      if_id_pc    <= '0;
      if_id_instr <= NOP_INSTR;
      hold_valid  <= 1'b0;
      hold_pc     <= '0;
      hold_instr  <= NOP_INSTR;
    end else if (redirect_valid) begin
      // A redirect overrides everything, including a consume in the same cycle.
      pc          <= redirect_pc & ALIGN_MASK;
      if_id_valid <= 1'b0;
      if_id_instr <= NOP_INSTR;
      hold_valid  <= 1'b0;
      case (state)
        S_WAIT:  state <= imem_rsp_valid ? S_REQ : S_DROP;
        S_DROP:  state <= imem_rsp_valid ? S_REQ : S_DROP;
        default: state <= S_REQ;
      endcase
    end else begin
      case (state)
        S_REQ: begin
          if (req_fire) begin
            pc_inflight <= pc;
            pc          <= pc + XLEN'(4);
            state       <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) state <= S_REQ;
        end
        S_DROP: begin
          // This response belongs to a fetch that was flushed.
          if (imem_rsp_valid) state <= S_REQ;
        end
        default: state <= S_REQ;
      endcase

      // ---- IF/ID slot update ----
      if (rsp_take && slot_free) begin
        if_id_valid <= 1'b1;
        if_id_pc    <= pc_inflight;
        if_id_instr <= imem_rsp_data;
      end else if (hold_valid && slot_free) begin
        if_id_valid <= 1'b1;
        if_id_pc    <= hold_pc;
        if_id_instr <= hold_instr;
        hold_valid  <= 1'b0;
      end else if (if_id_valid && id_ready) begin
        if_id_valid <= 1'b0;
        if_id_instr <= NOP_INSTR;
      end

      if (rsp_take && !slot_free) begin
        hold_valid <= 1'b1;
        hold_pc    <= pc_inflight;
        hold_instr <= imem_rsp_data;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic       slot_load;
  logic [1:0] discard_inc;

  always_comb begin
    slot_load   = !redirect_valid && slot_free && (rsp_take || hold_valid);
    discard_inc = 2'd0;
    if (redirect_valid) begin
      // The response is dropped, and any valid slot or hold entry is flushed.
      discard_inc = 2'((state != S_REQ) && imem_rsp_valid) + 2'(if_id_valid) + 2'(hold_valid);
    end else if (state == S_DROP && imem_rsp_valid) begin
      discard_inc = 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched   <= '0;
      perf_discarded <= '0;
    end else begin
      if (slot_load) perf_fetched <= perf_fetched + 64'd1;
      perf_discarded <= perf_discarded + 64'(discard_inc);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: a memory model with configurable ready and
// latency, plus a scoreboard of expected {pc, instr} pairs. Pairs are
// pushed on request acceptance and popped when decode consumes the slot.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        if_id_valid;
  logic [63:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        id_ready;
`ifdef FETCH_PERF_CNT_EN
  logic [63:0] perf_fetched;
  logic [63:0] perf_discarded;
`endif

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_id_valid    (if_id_valid),
    .if_id_pc       (if_id_pc),
    .if_id_instr    (if_id_instr),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetched   (perf_fetched),
    .perf_discarded (perf_discarded),
`endif
    .id_ready       (id_ready)
  );

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] acc_q[$];
  int          tests = 0;
  int          fails = 0;

  bit          pend;
  logic [63:0] pend_addr;
  int          pend_cnt;
  int          mem_lat = 1;
  bit          mem_ready = 1'b1;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return {~a[17:2], a[17:2]};
  endfunction

  // One clock: check consumption, take the edge, record acceptance,
  // then drive the memory response for the next cycle.
  task automatic cycle();
    bit          acc;
    logic [63:0] a;
    exp_t        e;
    #1;
    acc = rst_n && imem_req_valid && imem_req_ready;
    a   = imem_addr;
    if (rst_n && if_id_valid && id_ready && !redirect_valid) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected: got pc=%h instr=%h, expected no instruction", if_id_pc, if_id_instr);
      end else begin
        e = exp_q.pop_front();
        if (if_id_pc !== e.pc || if_id_instr !== e.instr) begin
          fails++;
          $display("FAIL sb_data: got pc=%h instr=%h, expected pc=%h instr=%h", if_id_pc, if_id_instr, e.pc, e.instr);
        end
      end
    end
    if (redirect_valid) exp_q.delete();
    @(posedge clk);
    if (acc) begin
      pend      = 1'b1;
      pend_addr = a;
      pend_cnt  = mem_lat;
      e.pc      = a;
      e.instr   = mem_word(a);
      exp_q.push_back(e);
      acc_q.push_back(a);
    end
    @(negedge clk);
    imem_req_ready = mem_ready;
    if (pend) begin
      if (pend_cnt <= 1) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(pend_addr);
        pend           = 1'b0;
      end else begin
        pend_cnt--;
        imem_rsp_valid = 1'b0;
      end
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0BAD0BAD;
    end
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    id_ready       = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0BAD0BAD;
    mem_ready      = 1'b1;
    mem_lat        = 1;
    imem_req_ready = 1'b1;
    pend           = 1'b0;
    exp_q.delete();
    acc_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_accept(input string name);
    int n;
    bit got;
    got = 1'b0;
    for (int i = 0; i < 12; i++) begin
      n = acc_q.size();
      cycle();
      if (acc_q.size() > n) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got no request acceptance, expected one within 12 cycles", name);
    end
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    id_ready       = 1'b1;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    @(posedge clk);
    @(negedge clk);
    tests++;
    if (imem_req_valid !== 1'b0) begin fails++; $display("FAIL rst_req_valid: got %b, expected 0", imem_req_valid); end
    tests++;
    if (if_id_valid !== 1'b0) begin fails++; $display("FAIL rst_if_id_valid: got %b, expected 0", if_id_valid); end
    tests++;
    if (if_id_pc !== 64'h0) begin fails++; $display("FAIL rst_if_id_pc: got %h, expected 0", if_id_pc); end
    tests++;
    if (if_id_instr !== NOP) begin fails++; $display("FAIL rst_if_id_instr: got %h, expected %h", if_id_instr, NOP); end
    tests++;
    if (imem_addr !== 64'h0) begin fails++; $display("FAIL rst_pc: got %h, expected 0", imem_addr); end
  endtask

  task automatic test_stream();
    int  cnt;
    bit  alt;
    logic v [20];
    do_reset();
    repeat (12) cycle();
    tests++;
    if (acc_q.size() < 3 || acc_q[0] !== 64'h0 || acc_q[1] !== 64'h4 || acc_q[2] !== 64'h8) begin
      fails++;
      $display("FAIL stream_addrs: got %0d requests, expected 0x0,0x4,0x8 first", acc_q.size());
    end
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      v[i] = if_id_valid;
      if (v[i]) cnt++;
      cycle();
    end
    alt = 1'b1;
    for (int i = 1; i < 20; i++) if (v[i] === v[i-1]) alt = 1'b0;
    tests++;
    if (cnt != 10) begin fails++; $display("FAIL stream_rate: got %0d valid cycles of 20, expected 10", cnt); end
    tests++;
    if (!alt) begin fails++; $display("FAIL stream_alternate: got valid=%b%b%b%b, expected alternating", v[0], v[1], v[2], v[3]); end
  endtask

  task automatic test_stall();
    int n0;
    bit seen;
    do_reset();
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (if_id_valid) begin seen = 1'b1; break; end
      cycle();
    end
    tests++;
    if (!seen) begin fails++; $display("FAIL stall_first_timeout: got no valid slot, expected one"); end
    id_ready = 1'b0;
    n0 = acc_q.size();
    for (int i = 0; i < 6; i++) begin
      cycle();
      tests++;
      if (if_id_valid !== 1'b1 || if_id_pc !== 64'h0 || if_id_instr !== mem_word(64'h0)) begin
        fails++;
        $display("FAIL stall_hold: got v=%b pc=%h instr=%h, expected v=1 pc=0 instr=%h", if_id_valid, if_id_pc, if_id_instr, mem_word(64'h0));
      end
    end
    tests++;
    if (acc_q.size() - n0 != 1) begin fails++; $display("FAIL stall_requests: got %0d requests, expected 1", acc_q.size() - n0); end
    tests++;
    if (imem_req_valid !== 1'b0) begin fails++; $display("FAIL stall_no_req: got %b, expected 0", imem_req_valid); end
    id_ready = 1'b1;
    cycle();
    tests++;
    if (if_id_valid !== 1'b1 || if_id_pc !== 64'h4) begin
      fails++;
      $display("FAIL stall_release: got v=%b pc=%h, expected v=1 pc=4", if_id_valid, if_id_pc);
    end
    repeat (8) cycle();
  endtask

  task automatic test_redirect_wait();
    do_reset();
    mem_lat = 2;
    wait_accept("redir_wait");
    redirect_valid = 1'b1;
    redirect_pc    = 64'h1002;
    cycle();
    redirect_valid = 1'b0;
    #1;
    tests++;
    if (if_id_valid !== 1'b0 || if_id_instr !== NOP) begin
      fails++;
      $display("FAIL redir_flush: got v=%b instr=%h, expected v=0 instr=%h", if_id_valid, if_id_instr, NOP);
    end
    tests++;
    if (imem_req_valid !== 1'b0) begin fails++; $display("FAIL redir_drop_req: got %b, expected 0", imem_req_valid); end
    cycle();
    #1;
    tests++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 64'h1000) begin
      fails++;
      $display("FAIL redir_target: got v=%b addr=%h, expected v=1 addr=1000", imem_req_valid, imem_addr);
    end
    mem_lat = 1;
    repeat (10) cycle();
  endtask

  task automatic test_redirect_rsp_same();
    bit seen;
    do_reset();
    repeat (4) cycle();
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (imem_rsp_valid) begin seen = 1'b1; break; end
      cycle();
    end
    tests++;
    if (!seen) begin fails++; $display("FAIL same_rsp_timeout: got no response, expected one"); end
    redirect_valid = 1'b1;
    redirect_pc    = 64'h2000;
    id_ready       = 1'b1;
    cycle();
    redirect_valid = 1'b0;
    #1;
    tests++;
    if (if_id_valid !== 1'b0) begin fails++; $display("FAIL same_slot: got %b, expected 0", if_id_valid); end
    tests++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 64'h2000) begin
      fails++;
      $display("FAIL same_next_req: got v=%b addr=%h, expected v=1 addr=2000", imem_req_valid, imem_addr);
    end
    repeat (8) cycle();
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1;
    redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
    cycle();
    redirect_valid = 1'b0;
    acc_q.delete();
    wait_accept("wrap_first");
    wait_accept("wrap_second");
    tests++;
    if (acc_q.size() < 2 || acc_q[0] !== 64'hFFFF_FFFF_FFFF_FFFC || acc_q[1] !== 64'h0) begin
      fails++;
      $display("FAIL wrap_addr: got %0d requests, expected FFFFFFFFFFFFFFFC then 0", acc_q.size());
    end
    repeat (8) cycle();
  endtask

  task automatic test_reset_mid();
    mem_lat = 2;
    wait_accept("rst_mid");
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (imem_req_valid !== 1'b0 || if_id_valid !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_async: got req=%b v=%b, expected 0 0", imem_req_valid, if_id_valid);
    end
    pend = 1'b0;
    exp_q.delete();
    imem_rsp_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n          = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEADBEEF;
    acc_q.delete();
    #1;
    tests++;
    if (imem_addr !== 64'h0) begin fails++; $display("FAIL rst_mid_pc: got %h, expected 0", imem_addr); end
`ifdef FETCH_PERF_CNT_EN
    tests++;
    if (perf_fetched !== 64'h0 || perf_discarded !== 64'h0) begin
      fails++;
      $display("FAIL rst_mid_perf: got %0d %0d, expected 0 0", perf_fetched, perf_discarded);
    end
`endif
    cycle();
    tests++;
    if (if_id_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_stale: got v=%b instr=%h, expected v=0", if_id_valid, if_id_instr); end
    repeat (10) cycle();
    tests++;
    if (acc_q.size() == 0 || acc_q[0] !== 64'h0) begin
      fails++;
      $display("FAIL rst_mid_first_req: got %0d requests, expected first at 0", acc_q.size());
    end
    mem_lat = 1;
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      mem_ready      = ($urandom_range(0, 3) != 0);
      mem_lat        = $urandom_range(1, 3);
      id_ready       = ($urandom_range(0, 2) != 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = {$urandom, $urandom};
      cycle();
    end
    redirect_valid = 1'b0;
    id_ready       = 1'b1;
    mem_ready      = 1'b1;
    repeat (20) cycle();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish, expected completion before 300000");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_wait();
    test_redirect_rsp_same();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
